// File: rtl/bus_enq_arbiter.sv
// ---------------------------------------------------------------------------
// bus_enq_arbiter
//
// Round-robin arbiter sharing one 32-bit word-serial enq channel among N
// requesters. Once a requester wins, the grant stays locked to it until the
// word carrying length <= 1 is accepted, so words of different messages are
// never interleaved on the output.
//
// Parameters:
//   N    number of requesters (2..16)
//   IDW  width of the grant index
//
// Ports:
//   CLK, nRST        clock / asynchronous active-low reset
//   req              per-requester "message pending"
//   in_enq__ENA      per-requester word strobe
//   in_enq_v         per-requester word data, 32 bits each
//   in_enq_length    per-requester remaining-word count, 16 bits each
//   in_enq__RDY      per-requester ready (only the granted bit can be high)
//   out_enq__ENA     forwarded strobe
//   out_enq_v        forwarded data
//   out_enq_length   forwarded length
//   out_enq__RDY     downstream ready
//   grant_valid      a message is locked
//   grant_id         locked requester; holds the last winner when idle
//
// Optional feature (macro BUS_ARB_STATS_EN):
//   msg_count        accepted last words, wraps
//   word_count       accepted words, wraps
// ---------------------------------------------------------------------------
module bus_enq_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    in_enq__ENA,
    input  logic [N*32-1:0] in_enq_v,
    input  logic [N*16-1:0] in_enq_length,
    output logic [N-1:0]    in_enq__RDY,
    output logic            out_enq__ENA,
    output logic [31:0]     out_enq_v,
    output logic [15:0]     out_enq_length,
    input  logic            out_enq__RDY,
    output logic            grant_valid,
    output logic [IDW-1:0]  grant_id
`ifdef BUS_ARB_STATS_EN
    ,
    output logic [31:0]     msg_count,
    output logic [31:0]     word_count
`endif
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]     state_q;
    logic [0:0]     state_d;
    // The grant register doubles as the round-robin pointer: both are loaded
    // with the winner at the same moment and never diverge.
    logic [IDW-1:0] grant_q;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] cand;
    logic           any_req;
    logic           accept;
    logic           last_word;

    // Round-robin search from grant_q+1. Walking the offsets from far to near
    // lets the nearest requesting index overwrite the others, so no
    // "found" flag is needed.
    always_comb begin : rr_search
        // NOTE: every variable gets a default before any conditional write,
        // otherwise a path that skips the assignment infers a latch.
        winner  = grant_q;
        cand    = grant_q;
        any_req = |req;
        for (int k = N; k >= 1; k--) begin
            cand = IDW'((int'(grant_q) + k) % N);
            if (req[cand]) begin
                winner = cand;
            end
        end
    end

    // Combinational forwarding of the granted requester; everything is zero
    // while idle.
    always_comb begin : fwd
        in_enq__RDY    = '0;
        out_enq__ENA   = 1'b0;
        out_enq_v      = '0;
        out_enq_length = '0;
        if (state_q == BUSY) begin
            in_enq__RDY[grant_q] = out_enq__RDY;
            out_enq__ENA         = in_enq__ENA[grant_q];
            out_enq_v            = in_enq_v[32*grant_q +: 32];
            out_enq_length       = in_enq_length[16*grant_q +: 16];
        end
    end

    assign accept    = out_enq__ENA & out_enq__RDY;
    // A length of 0 is treated as a single-word message.
    assign last_word = accept && (out_enq_length <= 16'd1);

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req)   state_d = BUSY;
            BUSY:    if (last_word) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            // N-1 so that the first search starts at requester 0.
            grant_q <= IDW'(N - 1);
        end else begin
            // NOTE: non-blocking assignments for all registered state, so
            // every flop samples the pre-edge values regardless of order.
            state_q <= state_d;
            if (state_q == IDLE && any_req) begin
                grant_q <= winner;
            end
        end
    end

    assign grant_valid = (state_q == BUSY);
    assign grant_id    = grant_q;

`ifdef BUS_ARB_STATS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            msg_count  <= '0;
            word_count <= '0;
        end else begin
            if (accept)    word_count <= word_count + 32'd1;
            if (last_word) msg_count  <= msg_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/bus_enq_arbiter.md
# bus_enq_arbiter

Round-robin arbiter that shares one 32-bit word-serial `enq` channel among N requesters, locking the grant for a whole message. A message is a run of words on `v`, each tagged with a remaining-word `length`; the final word carries `length` of 1. The block sits in front of the bus-to-128-bit packing adapter, so several producers can feed a single adapter without interleaving words of different messages.

## Interface
Parameters:
- `N`, default 4: number of requesters, legal range 2..16.
- `IDW`, default `$clog2(N)`: width of the grant index.

Ports:
- `CLK`  in  1  clock; all state changes on the rising edge.
- `nRST`  in  1  reset, asynchronous assertion, active-low.
- `req`  in  N  bit i high = requester i has a message pending.
- `in$enq__ENA`  in  N  per-requester word strobe; asserted only while the matching RDY bit is high.
- `in$enq$v`  in  N*32  word data; requester i owns bits [32i+31:32i].
- `in$enq$length`  in  N*16  remaining words including this one; requester i owns bits [16i+15:16i].
- `in$enq__RDY`  out  N  per-requester ready.
- `out$enq__ENA`  out  1  forwarded word strobe.
- `out$enq$v`  out  32  forwarded data.
- `out$enq$length`  out  16  forwarded length.
- `out$enq__RDY`  in  1  downstream ready.
- `grant_valid`  out  1  high while a message is locked.
- `grant_id`  out  IDW  index of the locked requester; holds the last winner when idle.

## Operation
States: IDLE and BUSY, each held in a register.

IDLE:
- All `in$enq__RDY` bits are 0, `out$enq__ENA`=0, `grant_valid`=0.
- Selection is round-robin. Search starts at `(last+1) mod N` and takes the first index with `req` high.
- If any `req` bit is high, the next state is BUSY, `grant_id` becomes the winner, and `last` becomes the winner.
- Arbitration does not depend on `out$enq__RDY`.

BUSY, with g = `grant_id`:
- `in$enq__RDY[g]` = `out$enq__RDY`. All other RDY bits are 0.
- `out$enq__ENA` = `in$enq__ENA[g]`.
- `out$enq$v` and `out$enq$length` are a combinational mux of requester g's slices.
- A word is accepted in any cycle where `out$enq__ENA` and `out$enq__RDY` are both high.
- If the accepted word has `length` ≤ 1, it ends the message and the next state is IDLE. A length of 0 is treated as a single-word message.
- Otherwise the state stays BUSY.
- `req` is ignored during BUSY. Dropping `req[g]` mid-message does not release the grant.

Outputs while idle:
- `out$enq$v` and `out$enq$length` drive 0.
- The ENA and RDY outputs of non-granted requesters are always 0.

## Timing
- Reset values: state=IDLE, `grant_id`=N-1, `last`=N-1 (so requester 0 has first priority), `grant_valid`=0. All RDY and ENA outputs are 0 and the data outputs are 0.
- Grant latency: `req` sampled high at edge k gives `grant_valid`=1 and RDY possible in the cycle after edge k. That is one cycle from request to first transfer opportunity.
- Forwarding is combinational, with zero added latency from word to output. Data is not buffered.
- Between messages: the last word is accepted at edge k, the state is IDLE for the cycle after k, and it re-arbitrates at edge k+1. So there is exactly one dead cycle between messages.
- With a single requester asserting `req` continuously, it is re-granted every message.
- Backpressure: while `out$enq__RDY`=0, RDY[g]=0 and the state and grant hold.
- Reset asserted mid-message: immediate return to the IDLE reset values. The partial message is abandoned and no word is forwarded after `nRST` falls.

## Configuration
- `BUS_ARB_STATS_EN` defined:
  - Adds output `msg_count` (32 bits), which increments by 1 on each accepted last word and wraps from 0xFFFFFFFF to 0.
  - Adds output `word_count` (32 bits), which increments on every accepted word and wraps.
  - Both counters reset to 0.
- Not defined: neither port exists and no counter logic is present. Arbitration behaviour is identical in both cases.

## Test plan
- Reset, then `req`=4'b0001 and a 3-word message with lengths 3,2,1 and `v`=0xA0,0xA1,0xA2 → `grant_id`=0 one cycle after `req`; the out side sees the same three words in order; IDLE after the 3rd word; `msg_count`=1, `word_count`=3.
- `req`=4'b1111 held, each requester sending 1-word messages → grant order 0,1,2,3,0 with exactly one idle cycle between grants.
- Requester 2 granted on a 4-word message while `req[1]` rises mid-message → no word from requester 1 is forwarded until requester 2's `length`=1 word is accepted; requester 1 is granted next.
- `out$enq__RDY` held low for 5 cycles in BUSY → RDY[g]=0 and no ENA during that window; the message resumes without word loss or duplication.
- `length`=0 word from the granted requester → treated as the last word; the state returns to IDLE.
- `nRST` pulsed low during the 2nd word of a 4-word message → all outputs return to reset values immediately; after release with `req`=4'b0100, `grant_id`=2 and a fresh message transfers correctly.
